// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock time-keeping blocks.
package alarm_clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MIN_LS_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_MS_MAX     = 4'd5;
  localparam logic [DIGIT_W-1:0] HR_MS_MAX      = 4'd2;
  localparam logic [DIGIT_W-1:0] HR_LS_MAX_AT_2 = 4'd3;
  localparam logic [DIGIT_W-1:0] HR_LS_MAX      = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] h_ms;
    logic [DIGIT_W-1:0] h_ls;
    logic [DIGIT_W-1:0] m_ms;
    logic [DIGIT_W-1:0] m_ls;
  } bcd_time_t;

  localparam bcd_time_t RESET_TIME = '{h_ms: 4'd0, h_ls: 4'd0, m_ms: 4'd0, m_ls: 4'd0};

  // True when the four digits form a legal 24 h time (00:00 .. 23:59).
  function automatic logic time_is_valid(bcd_time_t t);
    logic ok;
    ok = (t.h_ms <= HR_MS_MAX) && (t.h_ls <= HR_LS_MAX) &&
         (t.m_ms <= MIN_MS_MAX) && (t.m_ls <= MIN_LS_MAX);
    if (t.h_ms == HR_MS_MAX && t.h_ls > HR_LS_MAX_AT_2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous load and increment; wrap flags the
// carry into the next digit in the same cycle the increment is applied.
module bcd_digit_counter
  import alarm_clock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               wrap
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Load beats increment, so a wrap cannot be reported on a load cycle.
  assign wrap  = inc & ~load & (digit_q == max_val);
  assign digit = digit_q;

  // Next-digit selection.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (inc) begin
      digit_d = wrap ? '0 : digit_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= RST_VAL;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/time_counter.sv
// 24 h HH:MM time keeper: advances on one_minute, accepts validated user
// loads on the rising edge of load_new_c and tells the generator to realign.
module time_counter
  import alarm_clock_pkg::*;
#(
  parameter int MAX_HOUR = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               one_minute,
  input  logic               load_new_c,
  input  logic [DIGIT_W-1:0] new_time_h_ms,
  input  logic [DIGIT_W-1:0] new_time_h_ls,
  input  logic [DIGIT_W-1:0] new_time_m_ms,
  input  logic [DIGIT_W-1:0] new_time_m_ls,
  output logic [DIGIT_W-1:0] current_time_h_ms,
  output logic [DIGIT_W-1:0] current_time_h_ls,
  output logic [DIGIT_W-1:0] current_time_m_ms,
  output logic [DIGIT_W-1:0] current_time_m_ls,
  output logic               reset_count,
  output logic               load_err,
  output logic               hour_tick
);

  localparam logic [DIGIT_W-1:0] MAX_H_MS = DIGIT_W'(MAX_HOUR / 10);
  localparam logic [DIGIT_W-1:0] MAX_H_LS = DIGIT_W'(MAX_HOUR % 10);

  bcd_time_t          new_time;
  logic               load_q;
  logic               load_evt, load_ok, load_bad, advance;
  logic               m_ls_wrap, m_ms_wrap;
  logic [DIGIT_W-1:0] h_ms_q, h_ms_d, h_ls_q, h_ls_d;
  logic               reset_count_q, load_err_q, hour_tick_q;

  assign new_time = '{h_ms: new_time_h_ms, h_ls: new_time_h_ls,
                      m_ms: new_time_m_ms, m_ls: new_time_m_ls};

  // A load event swallows any coincident minute pulse, valid or not.
  assign load_evt = load_new_c & ~load_q;
  assign load_ok  = load_evt & time_is_valid(new_time);
  assign load_bad = load_evt & ~time_is_valid(new_time);
  assign advance  = one_minute & ~load_evt;

  bcd_digit_counter #(.RST_VAL(RESET_TIME.m_ls)) u_min_ls (
    .clk      (clk),
    .reset    (reset),
    .inc      (advance),
    .load     (load_ok),
    .load_val (new_time_m_ls),
    .max_val  (MIN_LS_MAX),
    .digit    (current_time_m_ls),
    .wrap     (m_ls_wrap)
  );

  bcd_digit_counter #(.RST_VAL(RESET_TIME.m_ms)) u_min_ms (
    .clk      (clk),
    .reset    (reset),
    .inc      (m_ls_wrap),
    .load     (load_ok),
    .load_val (new_time_m_ms),
    .max_val  (MIN_MS_MAX),
    .digit    (current_time_m_ms),
    .wrap     (m_ms_wrap)
  );

  // Hour pair: wraps from MAX_HOUR straight to 00 rather than per digit.
  always_comb begin
    h_ms_d = h_ms_q;
    h_ls_d = h_ls_q;
    if (load_ok) begin
      h_ms_d = new_time_h_ms;
      h_ls_d = new_time_h_ls;
    end else if (m_ms_wrap) begin
      if (h_ms_q == MAX_H_MS && h_ls_q == MAX_H_LS) begin
        h_ms_d = '0;
        h_ls_d = '0;
      end else if (h_ls_q == HR_LS_MAX) begin
        h_ms_d = h_ms_q + 4'd1;
        h_ls_d = '0;
      end else begin
        h_ls_d = h_ls_q + 4'd1;
      end
    end
  end

  // Hour digits, load edge detector and registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_ms_q        <= RESET_TIME.h_ms;
      h_ls_q        <= RESET_TIME.h_ls;
      load_q        <= 1'b0;
      reset_count_q <= 1'b0;
      load_err_q    <= 1'b0;
      hour_tick_q   <= 1'b0;
    end else begin
      h_ms_q        <= h_ms_d;
      h_ls_q        <= h_ls_d;
      load_q        <= load_new_c;
      reset_count_q <= load_ok;
      load_err_q    <= load_bad;
      hour_tick_q   <= m_ms_wrap;
    end
  end

  assign current_time_h_ms = h_ms_q;
  assign current_time_h_ls = h_ls_q;
  assign reset_count       = reset_count_q;
  assign load_err          = load_err_q;
  assign hour_tick         = hour_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a minutes-of-day reference model feeds
// expected values into a queue, and a monitor compares every cycle.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_hms = '0, n_hls = '0, n_mms = '0, n_mls = '0;
  logic [3:0] c_hms, c_hls, c_mms, c_mls;
  logic       reset_count, load_err, hour_tick;

  time_counter #(.MAX_HOUR(23)) dut (
    .clk               (clk),
    .reset             (reset),
    .one_minute        (one_minute),
    .load_new_c        (load_new_c),
    .new_time_h_ms     (n_hms),
    .new_time_h_ls     (n_hls),
    .new_time_m_ms     (n_mms),
    .new_time_m_ls     (n_mls),
    .current_time_h_ms (c_hms),
    .current_time_h_ls (c_hls),
    .current_time_m_ms (c_mms),
    .current_time_m_ls (c_mls),
    .reset_count       (reset_count),
    .load_err          (load_err),
    .hour_tick         (hour_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic [2:0]  pulses;  // {reset_count, load_err, hour_tick}
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rc_seen  = 0;
  int   le_seen  = 0;
  int   ht_seen  = 0;

  // Reference model state: minutes since midnight and the previous load level.
  int tod = 0;
  bit prev_ld = 0;

  function automatic logic [15:0] tod_bcd(int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] cur_time();
    return {c_hms, c_hls, c_mms, c_mls};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic cycle(input bit rst, input bit ld, input bit om, input logic [15:0] nt);
    exp_t e;
    int   h, m;
    bit   rc, le, ht;
    @(negedge clk);
    reset = rst;
    load_new_c = ld;
    one_minute = om;
    {n_hms, n_hls, n_mms, n_mls} = nt;
    rc = 0; le = 0; ht = 0;
    if (rst) begin
      tod = 0;
      prev_ld = 0;
    end else begin
      if (ld && !prev_ld) begin
        h = int'(nt[15:12]) * 10 + int'(nt[11:8]);
        m = int'(nt[7:4]) * 10 + int'(nt[3:0]);
        if (nt[15:12] <= 9 && nt[11:8] <= 9 && nt[7:4] <= 9 && nt[3:0] <= 9 &&
            h < 24 && m < 60) begin
          tod = h * 60 + m;
          rc = 1;
        end else begin
          le = 1;
        end
      end else if (om) begin
        tod = (tod + 1) % 1440;
        ht = (tod % 60) == 0;
      end
      prev_ld = ld;
    end
    e.t = tod_bcd(tod);
    e.pulses = {rc, le, ht};
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents a new registered result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      rc_seen += int'(reset_count);
      le_seen += int'(load_err);
      ht_seen += int'(hour_tick);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("time", int'(cur_time()), int'(e.t));
        chk("pulses", int'({reset_count, load_err, hour_tick}), int'(e.pulses));
      end
    end
  end

  initial begin
    int rc0, le0, ht0, wait_cyc;
    logic [15:0] nt;

    repeat (3) cycle(1, 0, 0, 16'h0000);
    #1;
    chk("reset_time", int'(cur_time()), 0);
    chk("reset_pulses", int'({reset_count, load_err, hour_tick}), 0);

    // Ten minutes from midnight.
    ht0 = ht_seen;
    cycle(0, 0, 0, 16'h0000);
    repeat (10) cycle(0, 0, 1, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    settle();
    chk("ten_min_time", int'(cur_time()), 16'h0010);
    chk("ten_min_no_tick", ht_seen - ht0, 0);

    // 12:59 then one minute.
    rc0 = rc_seen; ht0 = ht_seen;
    cycle(0, 1, 0, 16'h1259);
    cycle(0, 0, 0, 16'h1259);
    cycle(0, 0, 1, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    settle();
    chk("load1259_time", int'(cur_time()), 16'h1300);
    chk("load1259_rc", rc_seen - rc0, 1);
    chk("load1259_tick", ht_seen - ht0, 1);

    // 23:59 then one minute wraps to midnight.
    ht0 = ht_seen;
    cycle(0, 1, 0, 16'h2359);
    cycle(0, 0, 0, 16'h2359);
    cycle(0, 0, 1, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    settle();
    chk("wrap_time", int'(cur_time()), 16'h0000);
    chk("wrap_tick", ht_seen - ht0, 1);

    // Three rejected loads.
    rc0 = rc_seen; le0 = le_seen;
    cycle(0, 1, 0, 16'h2400); cycle(0, 0, 0, 16'h2400);
    cycle(0, 1, 0, 16'h0960); cycle(0, 0, 0, 16'h0960);
    cycle(0, 1, 0, 16'h1A00); cycle(0, 0, 0, 16'h1A00);
    settle();
    chk("bad_time", int'(cur_time()), 16'h0000);
    chk("bad_err_count", le_seen - le0, 3);
    chk("bad_no_rc", rc_seen - rc0, 0);

    // Load coincident with a minute pulse, then held high.
    rc0 = rc_seen;
    cycle(0, 1, 1, 16'h0530);
    repeat (20) cycle(0, 1, 0, 16'h0530);
    cycle(0, 0, 0, 16'h0530);
    settle();
    chk("hold_time", int'(cur_time()), 16'h0530);
    chk("hold_one_rc", rc_seen - rc0, 1);

    // Full day of back-to-back pulses from midnight.
    cycle(1, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    ht0 = ht_seen;
    repeat (1440) cycle(0, 0, 1, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    settle();
    chk("day_time", int'(cur_time()), 16'h0000);
    chk("day_ticks", ht_seen - ht0, 24);

    // Asynchronous reset mid-run, with load held through release.
    repeat (500) cycle(0, 0, 1, 16'h0000);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_time", int'(cur_time()), 16'h0000);
    cycle(1, 1, 0, 16'h0742);
    rc0 = rc_seen;
    cycle(0, 1, 0, 16'h0742);
    cycle(0, 1, 0, 16'h0742);
    settle();
    chk("rst_release_load", int'(cur_time()), 16'h0742);
    chk("rst_release_rc", rc_seen - rc0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) nt = tod_bcd(int'($urandom_range(0, 1439)));
      else nt = 16'($urandom());
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), nt);
    end
    cycle(0, 0, 0, 16'h0000);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Keeps the 24-hour wall-clock time (HH:MM, four BCD digits) for the alarm clock. It consumes the `one_minute` pulse from the time generator and advances the time by one minute per pulse. It also accepts a user-entered time and, on a valid load, drives `reset_count` back to the generator so that second and minute timing restart aligned to the new time.

## Interface
Parameters:
- `MAX_HOUR`, default 23: last hour value before wrap to 00 (decimal; fixed 24 h format).

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  system clock (same clock as the time generator).
- `reset`  in  1  asynchronous, active-high reset.
- `one_minute`  in  1  single-cycle advance pulse from the time generator.
- `load_new_c`  in  1  level request to load the new time; acted on at its rising edge only.
- `new_time_h_ms`  in  4  BCD hour tens to load.
- `new_time_h_ls`  in  4  BCD hour units to load.
- `new_time_m_ms`  in  4  BCD minute tens to load.
- `new_time_m_ls`  in  4  BCD minute units to load.
- `current_time_h_ms`  out  4  BCD hour tens.
- `current_time_h_ls`  out  4  BCD hour units.
- `current_time_m_ms`  out  4  BCD minute tens.
- `current_time_m_ls`  out  4  BCD minute units.
- `reset_count`  out  1  single-cycle pulse to the generator when a load is accepted.
- `load_err`  out  1  single-cycle pulse when a load is rejected.
- `hour_tick`  out  1  single-cycle pulse when the minutes wrap from 59 to 00.

## Operation
- Reset values:
  - All time digits are 0, so the time is 00:00.
  - `reset_count`, `load_err` and `hour_tick` are 0.
  - The edge-detect register for `load_new_c` is 0.
- Load detect:
  - `load_q` registers `load_new_c`.
  - A load event occurs when `load_new_c` is 1 and `load_q` is 0.
  - Holding `load_new_c` high produces exactly one event.
- Load validation (combinational on the `new_time_*` inputs, sampled on the load-event cycle). A load is valid when all of these hold:
  - `h_ms` ≤ 2
  - `h_ls` ≤ 9
  - if `h_ms` = 2, then `h_ls` ≤ 3
  - `m_ms` ≤ 5
  - `m_ls` ≤ 9
- Valid load:
  - All four digits take the new values.
  - `reset_count` pulses for 1 cycle.
  - `hour_tick` stays 0.
- Invalid load:
  - The time is unchanged.
  - `load_err` pulses for 1 cycle.
  - `reset_count` stays 0.
- Minute advance (on `one_minute` with no load event in the same cycle):
  - `m_ls` 0–8 increments by 1. At 9 it goes to 0 and carries.
  - On carry, `m_ms` 0–4 increments by 1. At 5 it goes to 0, carries to the hours, and `hour_tick` pulses.
  - Hour carry: if the hour is `MAX_HOUR` (23), it becomes 00.
  - Otherwise, when `h_ls` = 9, `h_ls` goes to 0 and `h_ms` increments.
  - Otherwise, `h_ls` increments.
- Priority when a load event and `one_minute` occur in the same cycle:
  - The load event wins and that minute pulse is discarded, whether the load is valid or invalid.
  - Rationale: after a valid load the generator restarts counting because of `reset_count`.
- Out-of-range state is never reachable; the digits are only written by validated loads or by the increment logic.

## Timing
- All outputs are registered.
- Digits update on the clock edge that samples the `one_minute` or load event, so they are visible the next cycle (1-cycle latency).
- `reset_count`, `load_err` and `hour_tick` assert in the cycle after the sampling edge. Each lasts exactly 1 cycle.
- `reset_count` is combinationally independent of `one_minute`, so there is no loop with the generator.
- The generator zeroes its counters while `reset_count` = 1. The first `one_minute` after an accepted load therefore arrives a full minute period later.
- An asynchronous reset mid-operation forces the reset values immediately. A `load_new_c` that is held high through the release of reset produces one event on the first clock edge after release.
- Back-to-back `one_minute` pulses on consecutive cycles (fastwatch mode) must each advance the time by one minute.

## Structure
- Shared package `alarm_clock_pkg`:
  - BCD digit width, 4.
  - Constants `MIN_LS_MAX`=9, `MIN_MS_MAX`=5, `HR_MS_MAX`=2, `HR_LS_MAX_AT_2`=3.
  - Reset time value, 00:00.
- Sub-module `bcd_digit_counter`:
  - Inputs: `clk`, `reset`, `inc`, `load`, `load_val`, `max_val`.
  - Outputs: `digit`, `wrap`.
  - Instantiated for the two minute digits.
- The hour pair uses dedicated logic because of the 23→00 rule.
- Validation and edge-detect logic live in `time_counter`.

## Test plan
- Reset, then 10 `one_minute` pulses → time reads 00:10; no `hour_tick`.
- Load 12:59, then one `one_minute` → `reset_count` pulses once after the load; time reads 13:00; `hour_tick` pulses once.
- Load 23:59, then one `one_minute` → time reads 00:00; `hour_tick` pulses.
- Load 24:00, then 09:60, then 1A:00 → `load_err` pulses 3 times; time unchanged; `reset_count` never asserts.
- Load event for 05:30 in the same cycle as `one_minute`, with `load_new_c` then held high for 20 cycles → time reads 05:30; exactly one `reset_count` pulse.
- 1440 consecutive single-cycle `one_minute` pulses from 00:00 → time returns to 00:00; 24 `hour_tick` pulses; reset asserted mid-run forces 00:00 immediately.
